// File: rtl/ahb_slave_mem_if.sv
// rtl/ahb_slave_mem_if.sv - AHB-2 slave-port signal bundle for ahb_slave_mem
interface ahb_slave_mem_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [3:0]  hmaster;
    logic        hmastlock;
    logic        hready_in;
    logic        hready;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata,
               hmaster, hmastlock, hready_in,
        input  hready, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata,
               hmaster, hmastlock, hready_in,
        output hready, hresp, hrdata
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB-2 slave with word memory, programmable wait states and ERROR response
module ahb_slave_mem #(
    parameter int unsigned MEM_DEPTH   = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic           hclk,
    input  logic           hreset,
    ahb_slave_mem_if.slave bus
);
    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        ST_READY,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          pend_wr_q, pend_wr_d;
    logic [AW-1:0] pend_idx_q, pend_idx_d;
    logic [3:0]    pend_be_q, pend_be_d;

    logic [31:0]   mem_q [MEM_DEPTH];

    logic          borrow;
    logic [31:0]   offset;
    logic          in_range;
    logic          aligned;
    logic          legal;
    logic [3:0]    be;
    logic          accept;
    logic          complete;
    logic          commit;
    logic [31:0]   rd_word;

    logic          hready_o;
    logic [1:0]    hresp_o;
    logic [31:0]   hrdata_o;

    logic          unused_bits;

    // Subtract with an explicit borrow so addresses below the window are rejected
    // without a constant compare when the window sits at address zero.
    assign {borrow, offset} = {1'b0, bus.haddr} - {1'b0, BASE_ADDR};
    assign in_range = !borrow && (offset[31:2] < 30'(MEM_DEPTH));

    always_comb begin
        aligned = 1'b0;
        be      = 4'b1111;
        case (bus.hsize)
            3'b000: begin
                aligned = 1'b1;
                be      = 4'b0001 << bus.haddr[1:0];
            end
            3'b001: begin
                aligned = !bus.haddr[0];
                be      = bus.haddr[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                aligned = (bus.haddr[1:0] == 2'b00);
                be      = 4'b1111;
            end
            default: begin
                aligned = 1'b0;
                be      = 4'b1111;
            end
        endcase
    end

    assign legal    = in_range && aligned;
    assign accept   = bus.hsel && bus.hready_in && bus.htrans[1] &&
                      ((state_q == ST_READY) || (state_q == ST_ERR2));
    // A pending legal transfer completes in the first READY cycle after its waits.
    assign complete = (state_q == ST_READY) && pend_q;
    assign commit   = complete && pend_wr_q && !hreset;
    assign rd_word  = mem_q[pend_idx_q];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_wr_d  = pend_wr_q;
        pend_idx_d = pend_idx_q;
        pend_be_d  = pend_be_q;
        hready_o   = 1'b1;
        hresp_o    = RESP_OKAY;
        hrdata_o   = 32'h0;

        case (state_q)
            ST_READY: begin
                pend_d = 1'b0;
                if (complete && !pend_wr_q) begin
                    hrdata_o = rd_word;
                end
            end
            ST_WAIT: begin
                hready_o = 1'b0;
                cnt_d    = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_READY;
                end
            end
            ST_ERR1: begin
                hready_o = 1'b0;
                hresp_o  = RESP_ERROR;
                state_d  = ST_ERR2;
            end
            ST_ERR2: begin
                hresp_o = RESP_ERROR;
                pend_d  = 1'b0;
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_READY;
                pend_d  = 1'b0;
            end
        endcase

        if (accept) begin
            pend_wr_d  = bus.hwrite;
            pend_idx_d = offset[AW+1:2];
            pend_be_d  = be;
            if (!legal) begin
                pend_d  = 1'b0;
                state_d = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
                pend_d  = 1'b1;
                cnt_d   = 4'(WAIT_STATES);
                state_d = ST_WAIT;
            end else begin
                pend_d  = 1'b1;
                state_d = ST_READY;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q    <= ST_READY;
            cnt_q      <= 4'd0;
            pend_q     <= 1'b0;
            pend_wr_q  <= 1'b0;
            pend_idx_q <= '0;
            pend_be_q  <= 4'b0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_wr_q  <= pend_wr_d;
            pend_idx_q <= pend_idx_d;
            pend_be_q  <= pend_be_d;
        end
    end

    // Memory is deliberately left out of reset; only the completion cycle writes it.
    always_ff @(posedge hclk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (pend_be_q[b]) begin
                    mem_q[pend_idx_q][8*b +: 8] <= bus.hwdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.hready = hready_o;
    assign bus.hresp  = hresp_o;
    assign bus.hrdata = hrdata_o;

    assign unused_bits = ^{bus.htrans[0], bus.hburst, bus.hmaster, bus.hmastlock, offset[1:0]};
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb/tb_ahb_slave_mem.sv - randomized model-checked bench for ahb_slave_mem (0 and 3 wait states)
module tb_ahb_slave_mem;
    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_4000;
    localparam int          WS1   = 3;
    localparam logic [1:0]  T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    logic hclk = 1'b0;
    logic hreset = 1'b1;
    always #5 hclk = ~hclk;

    int          sel = 0;
    logic        m_hsel = 1'b0;
    logic [31:0] m_haddr = 32'h0;
    logic [1:0]  m_htrans = T_IDLE;
    logic        m_hwrite = 1'b0;
    logic [2:0]  m_hsize = 3'b010;
    logic [2:0]  m_hburst = 3'b000;
    logic [31:0] m_hwdata = 32'h0;
    logic [3:0]  m_hmaster = 4'h0;
    logic        m_hmastlock = 1'b0;
    logic        stall = 1'b0;

    ahb_slave_mem_if bus0();
    ahb_slave_mem_if bus1();

    ahb_slave_mem #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hreset(hreset), .bus(bus0));
    ahb_slave_mem #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(WS1)) dut1 (
        .hclk(hclk), .hreset(hreset), .bus(bus1));

    logic        glob_hready;
    logic        o_hready;
    logic [1:0]  o_hresp;
    logic [31:0] o_hrdata;

    assign o_hready    = (sel == 1) ? bus1.hready : bus0.hready;
    assign o_hresp     = (sel == 1) ? bus1.hresp  : bus0.hresp;
    assign o_hrdata    = (sel == 1) ? bus1.hrdata : bus0.hrdata;
    assign glob_hready = o_hready && !stall;

    assign bus0.hsel = m_hsel && (sel == 0);
    assign bus1.hsel = m_hsel && (sel == 1);
    assign bus0.haddr = m_haddr;       assign bus1.haddr = m_haddr;
    assign bus0.htrans = m_htrans;     assign bus1.htrans = m_htrans;
    assign bus0.hwrite = m_hwrite;     assign bus1.hwrite = m_hwrite;
    assign bus0.hsize = m_hsize;       assign bus1.hsize = m_hsize;
    assign bus0.hburst = m_hburst;     assign bus1.hburst = m_hburst;
    assign bus0.hwdata = m_hwdata;     assign bus1.hwdata = m_hwdata;
    assign bus0.hmaster = m_hmaster;   assign bus1.hmaster = m_hmaster;
    assign bus0.hmastlock = m_hmastlock; assign bus1.hmastlock = m_hmastlock;
    assign bus0.hready_in = glob_hready; assign bus1.hready_in = glob_hready;

    typedef struct {
        logic       hready;
        logic [1:0] hresp;
        bit         rd;
        bit         wr;
        int         idx;
        logic [3:0] be;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mm [2][DEPTH];
    logic [3:0]  mk [2][DEPTH];
    bit          model_valid = 1'b0;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected response timeline per accepted transfer, from the bus rules alone.
    task automatic push_transfer();
        longint ai, off;
        int     sz, ws;
        bit     legal;
        exp_t   e;
        ai    = longint'(m_haddr);
        off   = ai - longint'(BASE);
        sz    = int'(m_hsize);
        legal = (off >= 0) && (off / 4 < DEPTH) && (sz <= 2) && ((ai % (64'd1 << sz)) == 0);
        e = '{hready: 1'b0, hresp: 2'b01, rd: 1'b0, wr: 1'b0, idx: 0, be: 4'h0};
        if (!legal) begin
            q.push_back(e);
            e.hready = 1'b1;
            q.push_back(e);
        end else begin
            ws = (sel == 1) ? WS1 : 0;
            e.hresp = 2'b00;
            for (int i = 0; i < ws; i++) q.push_back(e);
            e.hready = 1'b1;
            e.rd  = !m_hwrite;
            e.wr  = m_hwrite;
            e.idx = int'(off / 4);
            e.be  = 4'(((1 << (1 << sz)) - 1) << int'(ai % 4));
            q.push_back(e);
        end
    endtask

    always @(negedge hclk) begin : compare
        exp_t        e;
        logic [31:0] mask;
        e = '{hready: 1'b1, hresp: 2'b00, rd: 1'b0, wr: 1'b0, idx: 0, be: 4'h0};
        if (model_valid) begin
            if (q.size() > 0) e = q.pop_front();
            check("hready", {31'b0, o_hready}, {31'b0, e.hready});
            check("hresp", {30'b0, o_hresp}, {30'b0, e.hresp});
            if (e.rd) begin
                mask = 32'h0;
                for (int b = 0; b < 4; b++) if (mk[sel][e.idx][b]) mask[8*b +: 8] = 8'hFF;
                if (mask != 32'h0) check("hrdata", o_hrdata & mask, mm[sel][e.idx] & mask);
            end else begin
                check("hrdata_zero", o_hrdata, 32'h0);
            end
            if (e.wr && !hreset) begin
                for (int b = 0; b < 4; b++) begin
                    if (e.be[b]) begin
                        mm[sel][e.idx][8*b +: 8] = m_hwdata[8*b +: 8];
                        mk[sel][e.idx][b] = 1'b1;
                    end
                end
            end
        end
        if (hreset) begin
            q.delete();
            model_valid = 1'b1;
        end else if (model_valid && m_hsel && e.hready && !stall && m_htrans[1]) begin
            push_transfer();
        end
    end

    task automatic ap(input logic s, input logic [1:0] tr, input logic wr,
                      input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        bit ok;
        m_hsel = s; m_htrans = tr; m_hwrite = wr; m_haddr = a; m_hsize = sz;
        m_hburst = 3'($urandom); m_hmaster = 4'($urandom); m_hmastlock = 1'($urandom);
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge hclk);
            ok = glob_hready;
            @(posedge hclk);
            #1;
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL ap_timeout: got no hready expected hready within 40 cycles");
        end
        m_hwdata = wd;
    endtask

    task automatic idle();
        m_hsel = 1'b1; m_htrans = T_IDLE;
    endtask

    task automatic wait_done(output logic [31:0] d, output logic [1:0] r, output int lows);
        bit done;
        done = 1'b0; lows = 0; d = 32'h0; r = 2'b00;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge hclk);
            if (o_hready) begin
                done = 1'b1; d = o_hrdata; r = o_hresp;
            end else begin
                lows++;
            end
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: got no completion expected completion within 40 cycles");
        end
        @(posedge hclk);
        #1;
    endtask

    task automatic random_phase(input int n);
        logic [31:0] a;
        logic [2:0]  sz;
        logic [1:0]  tr;
        int r, lo;
        for (int i = 0; i < n; i++) begin
            r  = $urandom_range(0, 9);
            tr = (r < 6) ? T_NSEQ : (r < 8) ? T_SEQ : (r == 8) ? T_IDLE : T_BUSY;
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            r  = $urandom_range(0, 19);
            lo = $urandom_range(0, 3);
            if (sz <= 3'd2 && $urandom_range(0, 3) != 0) lo = lo & ~((1 << sz) - 1);
            if (r == 0)      a = BASE - 32'(4 * $urandom_range(1, 4)) + 32'(lo);
            else if (r == 1) a = BASE + DEPTH * 4 + 32'($urandom_range(0, 15));
            else             a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'(lo);
            ap(1'($urandom_range(0, 99) < 92), tr, 1'($urandom), a, sz, $urandom);
        end
        idle();
        repeat (8) begin @(posedge hclk); #1; end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no end expected end before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] d;
        logic [1:0]  r;
        int          lows;
        for (int s = 0; s < 2; s++) for (int i = 0; i < DEPTH; i++) mk[s][i] = 4'h0;

        hreset = 1'b1;
        @(posedge hclk); @(posedge hclk); #1;
        @(negedge hclk);
        check("reset_hready", {31'b0, o_hready}, 32'd1);
        check("reset_hresp", {30'b0, o_hresp}, 32'd0);
        check("reset_hrdata", o_hrdata, 32'h0);
        @(posedge hclk); #1;
        hreset = 1'b0;
        idle();
        @(posedge hclk); #1;

        // zero-wait write then back-to-back read of the same word
        ap(1, T_NSEQ, 1, BASE + 32'h10, 3'b010, 32'hDEAD_BEEF);
        ap(1, T_NSEQ, 0, BASE + 32'h10, 3'b010, $urandom);
        idle();
        wait_done(d, r, lows);
        check("fwd_data", d, 32'hDEAD_BEEF);
        check("fwd_resp", {30'b0, r}, 32'd0);
        check("fwd_lows", lows, 0);

        ap(1, T_NSEQ, 1, BASE + 32'h20, 3'b000, {4{8'h11}});
        ap(1, T_SEQ,  1, BASE + 32'h21, 3'b000, {4{8'h22}});
        ap(1, T_SEQ,  1, BASE + 32'h22, 3'b000, {4{8'h33}});
        ap(1, T_SEQ,  1, BASE + 32'h23, 3'b000, {4{8'h44}});
        ap(1, T_NSEQ, 0, BASE + 32'h20, 3'b010, $urandom);
        idle();
        wait_done(d, r, lows);
        check("byte_merge", d, 32'h4433_2211);
        ap(1, T_NSEQ, 1, BASE + 32'h22, 3'b001, {2{16'hABCD}});
        ap(1, T_NSEQ, 0, BASE + 32'h20, 3'b010, $urandom);
        idle();
        wait_done(d, r, lows);
        check("half_merge", d, 32'hABCD_2211);
        check("model_pin", mm[0][8], 32'hABCD_2211);

        ap(1, T_NSEQ, 1, BASE, 3'b010, 32'h0BAD_F00D);
        ap(1, T_NSEQ, 1, BASE + DEPTH * 4, 3'b010, 32'hFFFF_FFFF);
        idle();
        wait_done(d, r, lows);
        check("oor_resp", {30'b0, r}, 32'd1);
        check("oor_data", d, 32'h0);
        check("oor_lows", lows, 1);
        ap(1, T_NSEQ, 0, BASE + 32'h2, 3'b010, $urandom);
        idle();
        wait_done(d, r, lows);
        check("mis_resp", {30'b0, r}, 32'd1);
        check("mis_lows", lows, 1);
        // new address phase accepted during the second ERROR cycle
        ap(1, T_NSEQ, 0, BASE + 32'h2, 3'b010, $urandom);
        ap(1, T_NSEQ, 0, BASE, 3'b010, $urandom);
        idle();
        wait_done(d, r, lows);
        check("err2_accept_data", d, 32'h0BAD_F00D);
        check("err2_accept_resp", {30'b0, r}, 32'd0);

        stall = 1'b1;
        m_hsel = 1'b1; m_htrans = T_NSEQ; m_hwrite = 1'b0; m_haddr = BASE + 32'h10; m_hsize = 3'b010;
        @(negedge hclk);
        check("stall_hready", {31'b0, o_hready}, 32'd1);
        @(posedge hclk); #1;
        @(posedge hclk); #1;
        stall = 1'b0;
        ap(1, T_NSEQ, 0, BASE + 32'h10, 3'b010, $urandom);
        idle();
        wait_done(d, r, lows);
        check("stall_read", d, 32'hDEAD_BEEF);

        random_phase(250);

        sel = 1;
        @(posedge hclk); #1;
        ap(1, T_NSEQ, 1, BASE + 32'h4, 3'b010, 32'h1234_5678);
        idle();
        wait_done(d, r, lows);
        check("w3_write_lows", lows, WS1);
        ap(1, T_NSEQ, 0, BASE + 32'h4, 3'b010, $urandom);
        m_htrans = T_NSEQ; m_hwrite = 1'b0; m_haddr = BASE + 32'h8; m_hsize = 3'b010;
        wait_done(d, r, lows);
        check("w3_read_lows", lows, WS1);
        check("w3_read_data", d, 32'h1234_5678);
        idle();
        wait_done(d, r, lows);
        check("w3_next_lows", lows, WS1);

        ap(1, T_NSEQ, 1, BASE + 32'h4, 3'b010, 32'hCAFE_0000);
        idle();
        @(posedge hclk); #1;
        hreset = 1'b1;
        @(posedge hclk); #1;
        hreset = 1'b0;
        @(negedge hclk);
        check("rst_wait_hready", {31'b0, o_hready}, 32'd1);
        check("rst_wait_hresp", {30'b0, o_hresp}, 32'd0);
        check("rst_wait_hrdata", o_hrdata, 32'h0);
        @(posedge hclk); #1;
        ap(1, T_NSEQ, 0, BASE + 32'h4, 3'b010, $urandom);
        idle();
        wait_done(d, r, lows);
        check("rst_old_value", d, 32'h1234_5678);

        random_phase(250);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

AHB-2 slave responder backed by an internal word memory; it is the slave-side counterpart the arbiter's slave port drives (haddr, htrans, hwrite, hsize, hburst, hwdata, hmaster, hmastlock, hsel in; hready, hresp, hrdata out). It decodes transfers, inserts a programmable number of wait states, returns the AHB two-cycle ERROR response for illegal accesses, and performs byte-lane-correct little-endian reads and writes. It is used as the RTL slave behind the arbiter in integration benches and as a reference target for the slave agent.

## Interface
- MEM_DEPTH, 256: memory size in 32-bit words; power of two, 4..65536.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to MEM_DEPTH*4.
- WAIT_STATES, 0: wait cycles (hready=0) inserted before every OKAY completion; 0..15.

- hclk  in  1  bus clock; all logic on rising edge.
- hreset  in  1  synchronous, active-high reset.
- hsel  in  1  slave select from the decoder.
- haddr  in  32  transfer byte address.
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hwrite  in  1  1=write, 0=read.
- hsize  in  3  000 byte, 001 halfword, 010 word; larger is illegal.
- hburst  in  3  burst type; ignored (every beat handled independently).
- hwdata  in  32  write data, valid in the data phase.
- hmaster  in  4  current master id; ignored.
- hmastlock  in  1  locked-sequence flag; ignored.
- hready_in  in  1  global bus HREADY; address phase sampled only when high.
- hready  out  1  slave ready / transfer done.
- hresp  out  2  OKAY=00, ERROR=01 (RETRY/SPLIT never issued).
- hrdata  out  32  read data.

## Operation
- Accept: at a rising edge with hsel=1, hready_in=1, htrans[1]=1 and state READY or ERR2, latch haddr, hwrite, hsize. IDLE/BUSY or hsel=0: nothing latched, next cycle zero-wait OKAY.
- Illegal (any of): word index (haddr-BASE_ADDR)>>2 >= MEM_DEPTH or haddr<BASE_ADDR; hsize>010; hsize=001 with haddr[0]=1; hsize=010 with haddr[1:0]!=0.
- States:
  - READY: hready=1, hresp=OKAY. On accept: illegal -> ERR1; legal and WAIT_STATES>0 -> WAIT, cnt=WAIT_STATES; legal and WAIT_STATES=0 -> READY (data phase completes in next cycle).
  - WAIT: hready=0, hresp=OKAY; cnt-- each cycle; when cnt=1 -> READY (completion cycle). No accept in WAIT.
  - ERR1: hready=0, hresp=ERROR -> ERR2. No wait states for errors.
  - ERR2: hready=1, hresp=ERROR; accept evaluated as in READY; otherwise -> READY.
- Write: committed at the edge ending the completion cycle, using hwdata of that cycle; byte enables from hsize and latched haddr[1:0] (byte: lane addr[1:0]; halfword: lanes addr[1]*2+{0,1}; word: all). Illegal writes never modify memory.
- Read: hrdata = full 32-bit word at the latched address during the completion cycle (hready=1, OKAY); hrdata=0 in every other cycle including ERROR cycles.
- Forwarding: a read whose address phase coincides with the completion cycle of a write to the same word returns the merged post-write word.
- Memory contents are not reset.

## Timing
- Reset: state READY, hready=1, hresp=00, hrdata=0, cnt=0, pending transfer discarded (a write in flight is not committed).
- Zero-wait latency: address phase accepted at edge N; completion cycle is N..N+1 with hready=1; back-to-back transfers every cycle.
- With W waits: hready=0 for W cycles after acceptance, then one hready=1 cycle; total data phase W+1 cycles.
- Error: exactly two cycles (hready 0 then 1, hresp=ERROR both); the ERR2 cycle may accept a new address.
- hready_in low while this slave is in READY (another slave stalling): no acceptance, outputs OKAY/ready.
- Reset asserted mid-WAIT or ERR1: outputs return to reset values the next cycle.

## Test plan
- Zero-wait word write 32'hDEAD_BEEF to BASE+0x10, then read BASE+0x10 back-to-back -> read completion cycle hready=1, hresp=00, hrdata=32'hDEAD_BEEF (forwarding path).
- WAIT_STATES=3: read of BASE+0x4 -> hready low exactly 3 cycles, then 1 cycle high with data; no address accepted during waits.
- Byte writes 8'h11,8'h22,8'h33,8'h44 to BASE+0x20..0x23, word read -> 32'h4433_2211; halfword write 16'hABCD to BASE+0x22 -> word read 32'hABCD_2211.
- Out-of-range write (BASE+MEM_DEPTH*4) and misaligned word read (BASE+0x2) -> each: one cycle hready=0/hresp=01, one cycle hready=1/hresp=01, hrdata=0; memory unchanged.
- NONSEQ accepted in ERR2 cycle right after an error -> handled as normal legal transfer with correct data.
- Reset asserted during WAIT of a write -> hready=1, hresp=00, hrdata=0 next cycle; subsequent read shows old memory value.
